// File: rtl/adc0832_reader.sv
// ADC0832 receive path: skips the settling null bit(s), assembles the MSB-first word and
// optionally verifies it against the LSB-first repeat. Result is a byte plus a valid strobe.
module adc0832_reader #(
  parameter int DATA_WIDTH      = 8,
  parameter int NULL_BITS       = 1,
  parameter bit CHECK_LSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  command_read,
  input  logic                  adc_do,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  data_error,
  output logic                  busy
);
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] NULL_LAST = CW'(NULL_BITS - 1);
  localparam logic [CW-1:0] MSB_LAST  = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] LSB_LAST  = CW'(DATA_WIDTH - 2);

  typedef enum logic [2:0] {S_IDLE, S_NULL, S_MSB, S_LSB, S_HOLD} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] msb_sr_q, msb_sr_d;
  logic [DATA_WIDTH-3:0] lsb_sr_q, lsb_sr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;
  logic                  frame_ok;
  logic [DATA_WIDTH-1:0] msb_word;
  logic [DATA_WIDTH-1:0] lsb_word;

  assign frame_ok = enable & command_read;
  assign msb_word = {msb_sr_q[DATA_WIDTH-2:0], adc_do};
  // D1..D(N-2) sit in lsb_sr, the top bit arrives now and D0 is shared with the MSB phase.
  assign lsb_word = {adc_do, lsb_sr_q, msb_sr_q[0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    msb_sr_d = msb_sr_q;
    lsb_sr_d = lsb_sr_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    error_d  = error_q;
    case (state_q)
      S_IDLE: begin
        if (frame_ok) begin
          state_d  = S_NULL;
          cnt_d    = '0;
          msb_sr_d = '0;
          lsb_sr_d = '0;
        end
      end
      S_NULL: begin
        if (!frame_ok) begin
          state_d = S_IDLE;
        end else if (cnt_q == NULL_LAST) begin
          state_d = S_MSB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MSB: begin
        if (!frame_ok) begin
          state_d = S_IDLE;
        end else begin
          msb_sr_d = msb_word;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == MSB_LAST) begin
            cnt_d = '0;
            if (CHECK_LSB_FIRST) begin
              state_d = S_LSB;
            end else begin
              state_d = S_HOLD;
              data_d  = msb_word;
              valid_d = 1'b1;
              error_d = 1'b0;
            end
          end
        end
      end
      S_LSB: begin
        if (!frame_ok) begin
          state_d = S_IDLE;
        end else begin
          lsb_sr_d = {adc_do, lsb_sr_q[DATA_WIDTH-3:1]};
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == LSB_LAST) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            data_d  = msb_sr_q;
            error_d = (msb_sr_q != lsb_word);
            valid_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        // Stay here while command_read is held so one read yields exactly one strobe.
        if (!frame_ok) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      msb_sr_q <= '0;
      lsb_sr_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      msb_sr_q <= msb_sr_d;
      lsb_sr_q <= lsb_sr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign data_error = error_q;
  assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_adc0832_reader.sv
// Drives two reader instances (default config, and 2 null bits without LSB check) from one
// serial stream; a frame-position model predicts every output each cycle.
module tb_adc0832_reader;
  logic       clk = 1'b0;
  logic       rst_n, enable, command_read, adc_do;
  logic [7:0] data_out_a, data_out_b;
  logic       data_valid_a, data_error_a, busy_a;
  logic       data_valid_b, data_error_b, busy_b;

  int tests = 0;
  int fails = 0;

  adc0832_reader #(.DATA_WIDTH(8), .NULL_BITS(1), .CHECK_LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .command_read(command_read), .adc_do(adc_do),
    .data_out(data_out_a), .data_valid(data_valid_a), .data_error(data_error_a), .busy(busy_a)
  );

  adc0832_reader #(.DATA_WIDTH(8), .NULL_BITS(2), .CHECK_LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .command_read(command_read), .adc_do(adc_do),
    .data_out(data_out_b), .data_valid(data_valid_b), .data_error(data_error_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // Model state: edge number within the current frame (-1 = idle) and every sample seen.
  int         fe[2]   = '{-1, -1};
  bit         done[2] = '{1'b0, 1'b0};
  bit         bits[2][32];
  logic [7:0] exp_out[2];
  logic       exp_valid[2], exp_err[2], exp_busy[2];

  task automatic cmp(input string name, input int i, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s inst%0d got %h want %h at %0t", name, i, got, want, $time);
    end
  endtask

  task automatic model_step(input int i, input int nb, input bit chk);
    int         last;
    logic [7:0] w, l;
    last = nb + 8 + (chk ? 7 : 0);
    exp_valid[i] = 1'b0;
    if (!rst_n) begin
      fe[i] = -1; done[i] = 1'b0; exp_out[i] = 8'h00; exp_err[i] = 1'b0;
    end else if (fe[i] < 0) begin
      if (enable && command_read) begin fe[i] = 0; done[i] = 1'b0; end
    end else if (!(enable && command_read)) begin
      fe[i] = -1;
    end else if (!done[i]) begin
      fe[i]++;
      if (fe[i] > nb) bits[i][fe[i]-nb-1] = adc_do;
      if (fe[i] == last) begin
        for (int j = 0; j < 8; j++) w[7-j] = bits[i][j];
        l[0] = w[0];
        for (int k = 1; k < 8; k++) l[k] = bits[i][7+k];
        exp_out[i]   = w;
        exp_err[i]   = chk && (w != l);
        exp_valid[i] = 1'b1;
        done[i]      = 1'b1;
      end
    end
    exp_busy[i] = (fe[i] >= 0);
  endtask

  always begin
    @(posedge clk);
    model_step(0, 1, 1'b1);
    model_step(1, 2, 1'b0);
    #1;
    cmp("out",   0, data_out_a,           exp_out[0]);
    cmp("valid", 0, 8'(data_valid_a),     8'(exp_valid[0]));
    cmp("err",   0, 8'(data_error_a),     8'(exp_err[0]));
    cmp("busy",  0, 8'(busy_a),           8'(exp_busy[0]));
    cmp("out",   1, data_out_b,           exp_out[1]);
    cmp("valid", 1, 8'(data_valid_b),     8'(exp_valid[1]));
    cmp("err",   1, 8'(data_error_b),     8'(exp_err[1]));
    cmp("busy",  1, 8'(busy_b),           8'(exp_busy[1]));
  end

  task automatic step(input logic en, input logic cr, input logic d);
    @(negedge clk);
    rst_n = 1'b1; enable = en; command_read = cr; adc_do = d;
  endtask

  // Start edge, null samples, MSB-first word, then nlsb LSB-first bits (xor corrupt).
  task automatic frame(input logic [7:0] w, input int nulls, input int nlsb, input logic [7:0] corrupt);
    step(1'b1, 1'b1, 1'($urandom));
    for (int i = 0; i < nulls; i++) step(1'b1, 1'b1, 1'($urandom));
    for (int i = 7; i >= 0; i--) step(1'b1, 1'b1, w[i]);
    for (int k = 1; k <= nlsb; k++) step(1'b1, 1'b1, w[k] ^ corrupt[k]);
  endtask

  task automatic after_edge();
    @(posedge clk); #1;
  endtask

  initial begin
    int len;
    rst_n = 1'b0; enable = 1'b1; command_read = 1'b1; adc_do = 1'b1;
    repeat (3) @(negedge clk);
    after_edge();
    cmp("rst_out", 0, data_out_a, 8'h00);
    cmp("rst_busy", 0, 8'(busy_a), 8'h00);
    cmp("rst_valid", 1, 8'(data_valid_b), 8'h00);
    step(1'b0, 1'b0, 1'b0);

    // 0xA5 clean frame
    frame(8'hA5, 1, 7, 8'h00);
    after_edge();
    cmp("a5_out", 0, data_out_a, 8'hA5);
    cmp("a5_valid", 0, 8'(data_valid_a), 8'h01);
    cmp("a5_err", 0, 8'(data_error_a), 8'h00);
    step(1'b1, 1'b1, 1'b0);
    after_edge();
    cmp("a5_strobe_once", 0, 8'(data_valid_a), 8'h00);
    cmp("a5_busy_hold", 0, 8'(busy_a), 8'h01);
    step(1'b0, 1'b1, 1'b0);
    after_edge();
    cmp("a5_busy_drop", 0, 8'(busy_a), 8'h00);

    // D3 corrupted in the LSB-first phase
    frame(8'hA5, 1, 7, 8'b0000_1000);
    after_edge();
    cmp("d3_out", 0, data_out_a, 8'hA5);
    cmp("d3_err", 0, 8'(data_error_a), 8'h01);
    step(1'b1, 1'b1, 1'b0);
    after_edge();
    cmp("d3_strobe_once", 0, 8'(data_valid_a), 8'h00);
    step(1'b1, 1'b0, 1'b0);

    // abort after 4 MSB bits, then a full 0x3C
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    after_edge();
    cmp("abort_busy", 0, 8'(busy_a), 8'h00);
    cmp("abort_out", 0, data_out_a, 8'hA5);
    cmp("abort_valid", 0, 8'(data_valid_a), 8'h00);
    frame(8'h3C, 1, 7, 8'h00);
    after_edge();
    cmp("3c_out", 0, data_out_a, 8'h3C);
    cmp("3c_err", 0, 8'(data_error_a), 8'h00);
    step(1'b1, 1'b0, 1'b0);

    // reset at LSB cnt=3, then 0xFF
    frame(8'h96, 1, 3, 8'h00);
    @(negedge clk); rst_n = 1'b0;
    after_edge();
    cmp("mid_rst_out", 0, data_out_a, 8'h00);
    cmp("mid_rst_busy", 0, 8'(busy_a), 8'h00);
    cmp("mid_rst_valid", 0, 8'(data_valid_a), 8'h00);
    step(1'b0, 1'b0, 1'b0);
    frame(8'hFF, 1, 7, 8'h00);
    after_edge();
    cmp("ff_out", 0, data_out_a, 8'hFF);
    cmp("ff_valid", 0, 8'(data_valid_a), 8'h01);
    step(1'b1, 1'b0, 1'b0);

    // no-check instance: 2 null bits, 0x81, strobe after edge 10
    frame(8'h81, 2, 0, 8'h00);
    after_edge();
    cmp("b81_out", 1, data_out_b, 8'h81);
    cmp("b81_valid", 1, 8'(data_valid_b), 8'h01);
    cmp("b81_err", 1, 8'(data_error_b), 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'($urandom));
      after_edge();
      cmp("b81_no_restrobe", 1, 8'(data_valid_b), 8'h00);
    end
    step(1'b1, 1'b0, 1'b0);
    frame(8'h42, 2, 0, 8'h00);
    after_edge();
    cmp("b42_out", 1, data_out_b, 8'h42);
    step(1'b1, 1'b0, 1'b0);

    // back-to-back 0x00 then 0xFF, command_read low for one cycle between
    frame(8'h00, 1, 7, 8'h00);
    after_edge();
    cmp("b2b_00", 0, data_out_a, 8'h00);
    step(1'b1, 1'b0, 1'b0);
    frame(8'hFF, 1, 7, 8'h00);
    after_edge();
    cmp("b2b_ff", 0, data_out_a, 8'hFF);
    cmp("b2b_ff_err", 0, 8'(data_error_a), 8'h00);
    step(1'b1, 1'b0, 1'b0);

    // random frames of random length with random endings
    for (int n = 0; n < 80; n++) begin
      len = $urandom_range(2, 26);
      for (int j = 0; j < len; j++) step(1'b1, 1'b1, 1'($urandom));
      case ($urandom_range(0, 9))
        0:       begin @(negedge clk); rst_n = 1'b0; end
        1, 2:    step(1'b0, 1'b1, 1'($urandom));
        default: step(1'b1, 1'b0, 1'($urandom));
      endcase
      repeat ($urandom_range(0, 2)) step(1'($urandom), 1'b0, 1'($urandom));
    end

    step(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/adc0832_reader.md
Name: adc0832_reader

Overview:
- Receive side of the ADC0832 serial link.
- Once the command sequencer has shifted out the start/SGL/ODD bits and raised its read flag, this block samples the ADC DO line.
  - It discards the multiplexer-settling null bit(s).
  - It assembles the 8-bit MSB-first result.
  - It optionally checks that result against the LSB-first repeat.
- The result is presented as a parallel byte with a one-cycle valid strobe and a mismatch flag.
- The block sits between the ADC pins and the sensor-fusion logic, sharing the sequencer's clk and enable (CS-active) lines.

Parameters:
- DATA_WIDTH, 8: result width in bits. The LSB-first phase carries DATA_WIDTH-1 bits.
- NULL_BITS, 1: samples discarded after the read flag is seen. Legal range 1..3.
- CHECK_LSB_FIRST, 1: 1 captures and compares the LSB-first repeat; 0 ends the frame after the MSB-first phase.

Ports:
- clk  input  1  system/ADC serial clock. All sampling occurs on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- enable  input  1  conversion active (CS asserted). 0 aborts any frame.
- command_read  input  1  high once the command bits have been sent; held high for the rest of the frame.
- adc_do  input  1  serial data from the ADC DO pin.
- data_out  output  DATA_WIDTH  last completed result, MSB-first assembly.
- data_valid  output  1  one-cycle strobe: data_out and data_error were updated this cycle.
- data_error  output  1  1 = MSB-first and LSB-first words differed in the last completed frame.
- busy  output  1  high from frame start until return to IDLE.

Behaviour:
- Reset: synchronous, active-low. While rst_n=0 at a rising clk edge, the block forces:
  - state=IDLE, counters=0, shift registers=0;
  - data_out=0, data_valid=0, data_error=0, busy=0.
  - Reset mid-frame discards the partial frame. No strobe is issued.
- States: IDLE, NULL, MSB, LSB, HOLD.
- IDLE:
  - When enable=1 and command_read=1 at an edge (call it edge 0), go to NULL with cnt=0 and busy=1.
  - adc_do at edge 0 is ignored.
- NULL:
  - Discard adc_do at edges 1..NULL_BITS, then go to MSB with cnt=0.
- MSB:
  - At each edge, msb_sr <= {msb_sr[DATA_WIDTH-2:0], adc_do}, for DATA_WIDTH edges.
  - At the final MSB edge:
    - If CHECK_LSB_FIRST=1, go to LSB with cnt=0.
    - Otherwise update data_out <= assembled word, data_valid <= 1, data_error <= 0, and go to HOLD.
- LSB:
  - Edge k (k=0..DATA_WIDTH-2) captures bit D(k+1) into lsb_sr[k+1].
  - lsb_sr[0] is taken from msb_sr[0], since D0 is shared between the two phases.
  - At the final LSB edge: data_out <= msb word, data_error <= (msb word != lsb word), data_valid <= 1, go to HOLD.
- HOLD:
  - data_valid returns to 0 on the next edge. busy stays 1.
  - When enable=0 or command_read=0, go to IDLE with busy=0.
  - A new frame therefore requires command_read to be seen low at least once.
- Latency:
  - The last sampled bit is at edge NULL_BITS+DATA_WIDTH+(DATA_WIDTH-1 if CHECK_LSB_FIRST=1, else 0).
  - data_valid is high in the period following that edge.
  - Defaults: samples at edges 1 (null), 2..9 (MSB), 10..16 (LSB). data_valid is high after edge 16.
- Abort:
  - enable=0 at any edge in NULL, MSB or LSB: go to IDLE, busy=0, no strobe.
  - data_out and data_error keep their previous values.
  - command_read falling mid-frame is treated the same way.
- data_out and data_error change only with data_valid or reset.
- Simultaneous rst_n=0 with any other event: reset wins.

Test Plan:
- Defaults, ADC model returns 0xA5 (null, then 1,0,1,0,0,1,0,1, then LSB-first 0,1,0,0,1,0,1): data_out=0xA5, data_error=0, data_valid high exactly one cycle after edge 16, busy falls one cycle after enable drops.
- Same frame with D3 corrupted in the LSB-first phase: data_out=0xA5, data_error=1, single strobe.
- enable dropped after 4 MSB bits: no data_valid, busy=0 next cycle, data_out unchanged from the previous frame; the next full frame of 0x3C gives data_out=0x3C.
- rst_n=0 at LSB cnt=3: all outputs 0 next cycle; a subsequent 0xFF frame completes correctly.
- CHECK_LSB_FIRST=0, NULL_BITS=2, value 0x81: data_valid after edge 10, data_error=0; command_read held high produces no second strobe until it toggles low and high again.
- Back-to-back frames 0x00 then 0xFF, with command_read low for one cycle between them: two strobes, correct values, no stale bits carried over.
